// File: rtl/retire_stage_if.sv
// Retire-port and store-bus bundle between the ROB/memory side (master) and
// retire_stage (slave).
interface retire_stage_if #(
  parameter int WAYS      = 2,
  parameter int PREG_BITS = 6,
  parameter int AREG_BITS = 5,
  parameter int XLEN      = 32
);
  // Handshakes: ret_valid carries no ready, because the retire stage accepts
  // every lane it is offered in the cycle it is offered. mem_req/mem_gnt is
  // valid/ready: mem_addr/mem_data hold stable while mem_req is high, and a
  // store transfers on any cycle where mem_req and mem_gnt are both high.
  logic [WAYS-1:0]           ret_valid;
  logic [WAYS*PREG_BITS-1:0] ret_t_idx;
  logic [WAYS*PREG_BITS-1:0] ret_told_idx;
  logic [WAYS*AREG_BITS-1:0] ret_ar_idx;
  logic [WAYS-1:0]           ret_halt;
  logic [WAYS-1:0]           ret_mispredict;
  logic [WAYS*XLEN-1:0]      ret_target_pc;
  logic [WAYS-1:0]           ret_wr_mem;
  logic [WAYS*XLEN-1:0]      ret_mem_addr;
  logic [WAYS*XLEN-1:0]      ret_mem_data;
  logic                      mem_gnt;
  logic                      mem_req;
  logic [XLEN-1:0]           mem_addr;
  logic [XLEN-1:0]           mem_data;

  modport master (
    output ret_valid, ret_t_idx, ret_told_idx, ret_ar_idx, ret_halt,
           ret_mispredict, ret_target_pc, ret_wr_mem, ret_mem_addr,
           ret_mem_data, mem_gnt,
    input  mem_req, mem_addr, mem_data
  );

  modport slave (
    input  ret_valid, ret_t_idx, ret_told_idx, ret_ar_idx, ret_halt,
           ret_mispredict, ret_target_pc, ret_wr_mem, ret_mem_addr,
           ret_mem_data, mem_gnt,
    output mem_req, mem_addr, mem_data
  );
endinterface

// File: rtl/retire_stage.sv
// Retire stage: arch-map commit, free-list return, mispredict flush, retired
// store FIFO and halt sequencing. Define RETIRE_STATS_EN for retire counters.
module retire_stage #(
  parameter int WAYS      = 2,
  parameter int PREG_BITS = 6,
  parameter int AREG_BITS = 5,
  parameter int XLEN      = 32,
  parameter int SQ_DEPTH  = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  retire_stage_if.slave             bus,
  output logic [WAYS-1:0]           arch_wr_en,
  output logic [WAYS*AREG_BITS-1:0] arch_ar_idx,
  output logic [WAYS*PREG_BITS-1:0] arch_t_idx,
  output logic [WAYS-1:0]           free_en,
  output logic [WAYS*PREG_BITS-1:0] free_idx,
  output logic                      flush,
  output logic [XLEN-1:0]           flush_pc,
  output logic                      sq_almost_full,
  output logic                      sq_overflow,
  output logic                      halted,
  output logic [1:0]                dbg_state
`ifdef RETIRE_STATS_EN
  ,
  output logic [63:0]               stat_retired,
  output logic [31:0]               stat_flushes
`endif
);

  localparam int PTR_W = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int RET_W = $clog2(WAYS + 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HALT_DRAIN = 2'd1,
    HALTED     = 2'd2
  } state_e;

  state_e                    state_q;
  logic                      halted_q;
  logic [WAYS-1:0]           arch_wr_en_q, arch_wr_en_d;
  logic [WAYS*AREG_BITS-1:0] arch_ar_idx_q, arch_ar_idx_d;
  logic [WAYS*PREG_BITS-1:0] arch_t_idx_q, arch_t_idx_d;
  logic [WAYS-1:0]           free_en_q, free_en_d;
  logic [WAYS*PREG_BITS-1:0] free_idx_q, free_idx_d;
  logic                      flush_q, flush_d;
  logic [XLEN-1:0]           flush_pc_q, flush_pc_d;
  logic                      sq_overflow_q, sq_overflow_d;

  logic [XLEN-1:0]           sq_addr_q [SQ_DEPTH];
  logic [XLEN-1:0]           sq_data_q [SQ_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;

  logic                      deq;
  logic [CNT_W-1:0]          cnt_after_deq;
  logic [CNT_W-1:0]          n_enq;
  logic [RET_W-1:0]          n_ret;
  logic [WAYS-1:0]           enq_en;
  logic [PTR_W-1:0]          enq_slot [WAYS];
  logic                      halt_seen;
  logic                      stop;

  always_comb begin
    arch_wr_en_d  = '0;
    arch_ar_idx_d = '0;
    arch_t_idx_d  = '0;
    free_en_d     = '0;
    free_idx_d    = '0;
    flush_d       = 1'b0;
    flush_pc_d    = flush_pc_q;
    sq_overflow_d = sq_overflow_q;
    enq_en        = '0;
    n_enq         = '0;
    n_ret         = '0;
    halt_seen     = 1'b0;
    stop          = 1'b0;
    for (int i = 0; i < WAYS; i++) enq_slot[i] = '0;

    // The dequeue is counted before any enqueue so a same-cycle store can
    // reuse the slot the memory just drained.
    deq           = (count_q != '0) && bus.mem_gnt;
    cnt_after_deq = count_q - CNT_W'(deq);

    for (int i = 0; i < WAYS; i++) begin
      if (bus.ret_valid[i] && (state_q == RUN) && !stop) begin
        n_ret = n_ret + RET_W'(1);
        if (bus.ret_ar_idx[i*AREG_BITS +: AREG_BITS] != '0) begin
          arch_wr_en_d[i]                         = 1'b1;
          arch_ar_idx_d[i*AREG_BITS +: AREG_BITS] = bus.ret_ar_idx[i*AREG_BITS +: AREG_BITS];
          arch_t_idx_d[i*PREG_BITS +: PREG_BITS]  = bus.ret_t_idx[i*PREG_BITS +: PREG_BITS];
          free_en_d[i]                            = 1'b1;
          free_idx_d[i*PREG_BITS +: PREG_BITS]    = bus.ret_told_idx[i*PREG_BITS +: PREG_BITS];
        end
        if (bus.ret_wr_mem[i]) begin
          if ((cnt_after_deq + n_enq) < CNT_W'(SQ_DEPTH)) begin
            enq_en[i]   = 1'b1;
            enq_slot[i] = wr_ptr_q + PTR_W'(n_enq);
            n_enq       = n_enq + CNT_W'(1);
          end else begin
            sq_overflow_d = 1'b1;
          end
        end
        // Anything younger than a redirect or halt in the same group is dead.
        if (bus.ret_mispredict[i]) begin
          flush_d    = 1'b1;
          flush_pc_d = bus.ret_target_pc[i*XLEN +: XLEN];
          stop       = 1'b1;
        end
        if (bus.ret_halt[i]) begin
          halt_seen = 1'b1;
          stop      = 1'b1;
        end
      end
    end

    count_d  = cnt_after_deq + n_enq;
    wr_ptr_d = wr_ptr_q + PTR_W'(n_enq);
    rd_ptr_d = rd_ptr_q + PTR_W'(deq);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= RUN;
      halted_q      <= 1'b0;
      arch_wr_en_q  <= '0;
      arch_ar_idx_q <= '0;
      arch_t_idx_q  <= '0;
      free_en_q     <= '0;
      free_idx_q    <= '0;
      flush_q       <= 1'b0;
      flush_pc_q    <= '0;
      sq_overflow_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      arch_wr_en_q  <= arch_wr_en_d;
      arch_ar_idx_q <= arch_ar_idx_d;
      arch_t_idx_q  <= arch_t_idx_d;
      free_en_q     <= free_en_d;
      free_idx_q    <= free_idx_d;
      flush_q       <= flush_d;
      flush_pc_q    <= flush_pc_d;
      sq_overflow_q <= sq_overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      // No enqueues happen outside RUN, so count_d == 0 means the last
      // store has been granted and nothing remains outstanding.
      case (state_q)
        RUN: begin
          if (halt_seen) state_q <= HALT_DRAIN;
        end
        HALT_DRAIN: begin
          if (count_d == '0) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < WAYS; i++) begin
      if (enq_en[i]) begin
        sq_addr_q[enq_slot[i]] <= bus.ret_mem_addr[i*XLEN +: XLEN];
        sq_data_q[enq_slot[i]] <= bus.ret_mem_data[i*XLEN +: XLEN];
      end
    end
  end

`ifdef RETIRE_STATS_EN
  logic [63:0] stat_retired_q;
  logic [31:0] stat_flushes_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_retired_q <= '0;
      stat_flushes_q <= '0;
    end else begin
      stat_retired_q <= stat_retired_q + 64'(n_ret);
      stat_flushes_q <= stat_flushes_q + 32'(flush_d);
    end
  end

  assign stat_retired = stat_retired_q;
  assign stat_flushes = stat_flushes_q;
`endif

  assign bus.mem_req     = (count_q != '0);
  assign bus.mem_addr    = bus.mem_req ? sq_addr_q[rd_ptr_q] : '0;
  assign bus.mem_data    = bus.mem_req ? sq_data_q[rd_ptr_q] : '0;
  assign sq_almost_full  = (CNT_W'(SQ_DEPTH) - count_q) < CNT_W'(WAYS);
  assign sq_overflow     = sq_overflow_q;
  assign arch_wr_en      = arch_wr_en_q;
  assign arch_ar_idx     = arch_ar_idx_q;
  assign arch_t_idx      = arch_t_idx_q;
  assign free_en         = free_en_q;
  assign free_idx        = free_idx_q;
  assign flush           = flush_q;
  assign flush_pc        = flush_pc_q;
  assign halted          = halted_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_retire_stage.sv
// Directed self-checking bench for retire_stage (default build, stats off).
module tb_retire_stage;
  localparam int WAYS = 2, PB = 6, AB = 5, XL = 32, SQD = 4;

  logic clock = 1'b0;
  logic reset;
  logic [WAYS-1:0]    arch_wr_en, free_en;
  logic [WAYS*AB-1:0] arch_ar_idx;
  logic [WAYS*PB-1:0] arch_t_idx, free_idx;
  logic               flush, sq_almost_full, sq_overflow, halted;
  logic [XL-1:0]      flush_pc;
  logic [1:0]         dbg_state;

  int tests = 0;
  int fails = 0;

  retire_stage_if #(.WAYS(WAYS), .PREG_BITS(PB), .AREG_BITS(AB), .XLEN(XL)) bus ();

  retire_stage #(.WAYS(WAYS), .PREG_BITS(PB), .AREG_BITS(AB), .XLEN(XL), .SQ_DEPTH(SQD)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .arch_wr_en(arch_wr_en), .arch_ar_idx(arch_ar_idx), .arch_t_idx(arch_t_idx),
    .free_en(free_en), .free_idx(free_idx), .flush(flush), .flush_pc(flush_pc),
    .sq_almost_full(sq_almost_full), .sq_overflow(sq_overflow), .halted(halted),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_lanes();
    bus.ret_valid = '0; bus.ret_t_idx = '0; bus.ret_told_idx = '0;
    bus.ret_ar_idx = '0; bus.ret_halt = '0; bus.ret_mispredict = '0;
    bus.ret_target_pc = '0; bus.ret_wr_mem = '0;
    bus.ret_mem_addr = '0; bus.ret_mem_data = '0;
  endtask

  task automatic do_reset();
    clear_lanes();
    bus.mem_gnt = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_lane(input int l, input logic [AB-1:0] ar, input logic [PB-1:0] t,
                          input logic [PB-1:0] told);
    bus.ret_valid[l] = 1'b1;
    bus.ret_ar_idx[l*AB +: AB] = ar;
    bus.ret_t_idx[l*PB +: PB] = t;
    bus.ret_told_idx[l*PB +: PB] = told;
  endtask

  task automatic set_store(input int l, input logic [XL-1:0] a, input logic [XL-1:0] d);
    bus.ret_valid[l] = 1'b1;
    bus.ret_wr_mem[l] = 1'b1;
    bus.ret_mem_addr[l*XL +: XL] = a;
    bus.ret_mem_data[l*XL +: XL] = d;
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    tests++; if (arch_wr_en !== 2'b00) begin fails++; $display("FAIL reset_arch_wr_en got %b exp 00", arch_wr_en); end
    tests++; if (free_en !== 2'b00) begin fails++; $display("FAIL reset_free_en got %b exp 00", free_en); end
    tests++; if ({flush, flush_pc} !== 33'd0) begin fails++; $display("FAIL reset_flush got %b/%h exp 0/0", flush, flush_pc); end
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b exp 0", bus.mem_req); end
    tests++; if ({sq_almost_full, sq_overflow, halted} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {sq_almost_full, sq_overflow, halted}); end
    tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_commit();
    clear_lanes();
    set_lane(0, 5'd3, 6'd40, 6'd12);
    set_lane(1, 5'd0, 6'd7, 6'd9);
    tick();
    clear_lanes();
    tests++; if (arch_wr_en !== 2'b01) begin fails++; $display("FAIL commit_wr_en got %b exp 01", arch_wr_en); end
    tests++; if (arch_ar_idx[4:0] !== 5'd3) begin fails++; $display("FAIL commit_ar got %0d exp 3", arch_ar_idx[4:0]); end
    tests++; if (arch_t_idx[5:0] !== 6'd40) begin fails++; $display("FAIL commit_t got %0d exp 40", arch_t_idx[5:0]); end
    tests++; if (free_en !== 2'b01) begin fails++; $display("FAIL commit_free_en got %b exp 01", free_en); end
    tests++; if (free_idx[5:0] !== 6'd12) begin fails++; $display("FAIL commit_free_idx got %0d exp 12", free_idx[5:0]); end
    set_lane(0, 5'd1, 6'd20, 6'd2);
    set_lane(1, 5'd31, 6'd63, 6'd5);
    tick();
    clear_lanes();
    tests++; if (arch_wr_en !== 2'b11) begin fails++; $display("FAIL commit2_wr_en got %b exp 11", arch_wr_en); end
    tests++; if (arch_ar_idx !== {5'd31, 5'd1}) begin fails++; $display("FAIL commit2_ar got %h exp %h", arch_ar_idx, {5'd31, 5'd1}); end
    tests++; if (arch_t_idx !== {6'd63, 6'd20}) begin fails++; $display("FAIL commit2_t got %h exp %h", arch_t_idx, {6'd63, 6'd20}); end
    tests++; if (free_idx !== {6'd5, 6'd2}) begin fails++; $display("FAIL commit2_free got %h exp %h", free_idx, {6'd5, 6'd2}); end
    tick();
    tests++; if ({arch_wr_en, free_en} !== 4'b0000) begin fails++; $display("FAIL commit_idle got %b exp 0000", {arch_wr_en, free_en}); end
  endtask

  task automatic test_mispredict();
    clear_lanes();
    set_lane(0, 5'd4, 6'd33, 6'd17);
    bus.ret_mispredict[0] = 1'b1;
    bus.ret_target_pc[31:0] = 32'h0000_0100;
    set_lane(1, 5'd6, 6'd34, 6'd18);
    tick();
    clear_lanes();
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL mispredict_flush got %b exp 1", flush); end
    tests++; if (flush_pc !== 32'h100) begin fails++; $display("FAIL mispredict_pc got %h exp 00000100", flush_pc); end
    tests++; if (arch_wr_en !== 2'b01) begin fails++; $display("FAIL mispredict_commit got %b exp 01", arch_wr_en); end
    tests++; if (arch_ar_idx[4:0] !== 5'd4) begin fails++; $display("FAIL mispredict_ar got %0d exp 4", arch_ar_idx[4:0]); end
    tick();
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL mispredict_pulse got %b exp 0", flush); end
  endtask

  task automatic test_store_backpressure();
    clear_lanes();
    bus.mem_gnt = 1'b0;
    set_store(0, 32'h10, 32'hAA);
    set_store(1, 32'h14, 32'hBB);
    tick();
    clear_lanes();
    tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL bp_req got %b exp 1", bus.mem_req); end
    tests++; if (bus.mem_data !== 32'hAA) begin fails++; $display("FAIL bp_data got %h exp 000000aa", bus.mem_data); end
    for (int c = 0; c < 3; c++) begin
      tests++; if (bus.mem_addr !== 32'h10) begin fails++; $display("FAIL bp_hold%0d got %h exp 00000010", c, bus.mem_addr); end
      tick();
    end
    bus.mem_gnt = 1'b1;
    tick();
    tests++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h14}) begin fails++; $display("FAIL bp_second got %b/%h exp 1/00000014", bus.mem_req, bus.mem_addr); end
    tests++; if (bus.mem_data !== 32'hBB) begin fails++; $display("FAIL bp_second_data got %h exp 000000bb", bus.mem_data); end
    tick();
    bus.mem_gnt = 1'b0;
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL bp_empty got %b exp 0", bus.mem_req); end
  endtask

  task automatic test_full_fifo();
    logic [XL-1:0] exp_q[$];
    // Two stores arrive at a full FIFO while one drains: one in, one dropped.
    do_reset();
    set_store(0, 32'h20, 32'h1); set_store(1, 32'h24, 32'h2); tick(); clear_lanes();
    set_store(0, 32'h28, 32'h3); set_store(1, 32'h2C, 32'h4); tick(); clear_lanes();
    tests++; if ({sq_almost_full, sq_overflow} !== 2'b10) begin fails++; $display("FAIL full_flags got %b exp 10", {sq_almost_full, sq_overflow}); end
    bus.mem_gnt = 1'b1;
    set_store(0, 32'h30, 32'h5); set_store(1, 32'h34, 32'h6);
    tick();
    clear_lanes();
    tests++; if (sq_overflow !== 1'b1) begin fails++; $display("FAIL full_overflow got %b exp 1", sq_overflow); end
    exp_q = '{32'h24, 32'h28, 32'h2C, 32'h30};
    while (exp_q.size() > 0) begin
      tests++; if (bus.mem_addr !== exp_q[0]) begin fails++; $display("FAIL full_drain got %h exp %h", bus.mem_addr, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
    end
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL full_dropped got req %b exp 0", bus.mem_req); end
    // Single store at a full FIFO while one drains: accepted, no overflow.
    do_reset();
    set_store(0, 32'h50, 32'h1); set_store(1, 32'h54, 32'h2); tick(); clear_lanes();
    set_store(0, 32'h58, 32'h3); set_store(1, 32'h5C, 32'h4); tick(); clear_lanes();
    bus.mem_gnt = 1'b1;
    set_store(0, 32'h40, 32'h9);
    tick();
    clear_lanes();
    tests++; if (sq_overflow !== 1'b0) begin fails++; $display("FAIL one_overflow got %b exp 0", sq_overflow); end
    exp_q = '{32'h54, 32'h58, 32'h5C, 32'h40};
    while (exp_q.size() > 0) begin
      tests++; if (bus.mem_addr !== exp_q[0]) begin fails++; $display("FAIL one_drain got %h exp %h", bus.mem_addr, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
    end
    bus.mem_gnt = 1'b0;
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL one_empty got %b exp 0", bus.mem_req); end
  endtask

  task automatic test_halt();
    do_reset();
    set_store(0, 32'h60, 32'h11); set_store(1, 32'h64, 32'h22); tick(); clear_lanes();
    set_lane(0, 5'd0, 6'd0, 6'd0);
    bus.ret_halt[0] = 1'b1;
    tick();
    clear_lanes();
    tests++; if ({dbg_state, halted} !== {2'd1, 1'b0}) begin fails++; $display("FAIL halt_drain got %0d/%b exp 1/0", dbg_state, halted); end
    tick();
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    tests++; if ({halted, bus.mem_addr} !== {1'b0, 32'h64}) begin fails++; $display("FAIL halt_first_gnt got %b/%h exp 0/00000064", halted, bus.mem_addr); end
    tick();
    tests++; if ({halted, bus.mem_req} !== 2'b01) begin fails++; $display("FAIL halt_wait got %b exp 01", {halted, bus.mem_req}); end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    tests++; if ({halted, bus.mem_req} !== 2'b10) begin fails++; $display("FAIL halt_done got %b exp 10", {halted, bus.mem_req}); end
    set_lane(0, 5'd7, 6'd44, 6'd21);
    bus.ret_mispredict[0] = 1'b1;
    set_store(1, 32'h70, 32'h33);
    tick();
    clear_lanes();
    tests++; if ({arch_wr_en, free_en, flush} !== 5'b0) begin fails++; $display("FAIL halt_ignore got %b exp 00000", {arch_wr_en, free_en, flush}); end
    tests++; if ({bus.mem_req, halted} !== 2'b01) begin fails++; $display("FAIL halt_sticky got %b exp 01", {bus.mem_req, halted}); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    set_store(0, 32'h80, 32'h1); set_store(1, 32'h84, 32'h2); tick(); clear_lanes();
    tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL mid_pre_req got %b exp 1", bus.mem_req); end
    reset = 1'b1;
    set_lane(0, 5'd3, 6'd10, 6'd11);
    bus.ret_mispredict[0] = 1'b1;
    tick();
    reset = 1'b0;
    clear_lanes();
    tests++; if ({bus.mem_req, sq_almost_full} !== 2'b00) begin fails++; $display("FAIL mid_req got %b exp 00", {bus.mem_req, sq_almost_full}); end
    tests++; if ({arch_wr_en, free_en, flush, halted, sq_overflow} !== 7'b0) begin fails++; $display("FAIL mid_outputs got %b exp 0", {arch_wr_en, free_en, flush, halted, sq_overflow}); end
    tests++; if ({bus.mem_addr, flush_pc} !== 64'd0) begin fails++; $display("FAIL mid_buses got %h exp 0", {bus.mem_addr, flush_pc}); end
  endtask

  // Sequence and final report
  initial begin
    reset = 1'b1;
    clear_lanes();
    bus.mem_gnt = 1'b0;
    test_reset();
    test_commit();
    test_mispredict();
    test_store_backpressure();
    test_full_fifo();
    test_halt();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
